// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the returned instruction into the IF/ID pipeline register.
// Redirects outrank stalls; flush squashes IF/ID without touching the PC.
module fetch_stage #(
  parameter int                  PC_W      = 16,
  parameter int                  INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter int                  PC_STEP   = 2,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               flush,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [15:0]        fetch_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus2;
    logic               valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_seq;
  ifid_t           ifid;
  logic            load_ifid;

  // Sequential PC wraps naturally at PC_W bits.
  assign pc_seq    = pc + PC_W'(PC_STEP);
  // A real instruction enters IF/ID only when nothing squashes or holds it.
  assign load_ifid = !redirect && !flush && !stall;

  // PC, IF/ID register, sticky misalign flag and delivered-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      ifid         <= BUBBLE;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      // Redirect forces even alignment; bit 0 only feeds the error flag.
      if (redirect)    pc <= {redirect_target[PC_W-1:1], 1'b0};
      else if (!stall) pc <= pc_seq;

      if (redirect || flush) ifid <= BUBBLE;
      else if (!stall)       ifid <= '{instr: imem_instr, pc_plus2: pc_seq, valid: 1'b1};

      if (redirect && redirect_target[0]) misalign_err <= 1'b1;
      if (load_ifid) fetch_count <= fetch_count + 16'd1;
    end
  end

  assign imem_addr      = pc;
  assign if_id_instr    = ifid.instr;
  assign if_id_pc_plus2 = ifid.pc_plus2;
  assign if_id_valid    = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/flush
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr, imem_instr;
  logic        stall = 1'b0, redirect = 1'b0, flush = 1'b0;
  logic [15:0] redirect_target = '0;
  logic [15:0] if_id_instr, if_id_pc_plus2;
  logic        if_id_valid, misalign_err;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:32767];
  int n_vec = 0, n_err = 0;

  // Model state: what the fetch stage should hold after each edge.
  logic [15:0] m_pc, m_instr, m_pc2, m_cnt;
  logic        m_valid, m_err;

  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .flush(flush), .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  imem_addr,      m_pc);
    chk({tag, ".instr"}, if_id_instr,    m_instr);
    chk({tag, ".pc2"},   if_id_pc_plus2, m_pc2);
    chk({tag, ".valid"}, if_id_valid,    m_valid);
    chk({tag, ".err"},   misalign_err,   m_err);
    chk({tag, ".cnt"},   fetch_count,    m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_err = 1'b0; m_cnt = 16'h0000;
  endtask

  // One clock: what happens to the fetch stage given the request this cycle.
  task automatic step(input logic st, input logic rd, input logic [15:0] tgt,
                      input logic fl, input string tag);
    logic [15:0] fetched, next_seq;
    stall = st; redirect = rd; redirect_target = tgt; flush = fl;
    fetched  = mem[m_pc >> 1];
    next_seq = 16'((32'(m_pc) + 2) % 65536);
    if (rd || fl) begin
      m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = fetched; m_pc2 = next_seq; m_valid = 1'b1;
      m_cnt = 16'((32'(m_cnt) + 1) % 65536);
    end
    if (rd) begin
      m_pc = tgt & 16'hFFFE;
      if (tgt % 2 == 1) m_err = 1'b1;
    end else if (!st) m_pc = next_seq;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 0; redirect = 0; flush = 0;
    model_reset();
    #1 chk_all("reset");
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1010; mem[1] = 16'h1231; mem[2] = 16'h145E; mem[3] = 16'h167F;
    model_reset();

    // Asynchronous reset visible before any clock edge.
    #1 chk_all("por");
    @(negedge clk) rst = 1'b0;

    // Free-running fetch of the first four instructions.
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0, "run");
    chk("run4.addr", imem_addr, 16'h0008);
    chk("run4.instr", if_id_instr, 16'h167F);
    chk("run4.cnt", fetch_count, 16'd4);

    // Two-cycle stall with PC=4 and 1231 in IF/ID.
    do_reset();
    step(0, 0, 16'h0, 0, "pre_stall");
    step(0, 0, 16'h0, 0, "pre_stall");
    step(1, 0, 16'h0, 0, "stall");
    step(1, 0, 16'h0, 0, "stall");
    chk("stall.addr", imem_addr, 16'h0004);
    chk("stall.instr", if_id_instr, 16'h1231);
    chk("stall.cnt", fetch_count, 16'd2);
    step(0, 0, 16'h0, 0, "release");
    chk("release.instr", if_id_instr, 16'h145E);

    // Redirect outranks a simultaneous stall.
    do_reset();
    step(0, 0, 16'h0, 0, "pre_redir");
    step(1, 1, 16'h000A, 0, "redir");
    chk("redir.valid", if_id_valid, 1'b0);
    step(0, 0, 16'h0, 0, "post_redir");
    chk("post_redir.instr", if_id_instr, mem[5]);

    // Odd target: aligned PC, sticky error until reset.
    step(0, 1, 16'h0007, 0, "misalign");
    chk("misalign.addr", imem_addr, 16'h0006);
    step(0, 1, 16'h0010, 0, "redir_even");
    step(0, 0, 16'h0, 0, "run");
    chk("sticky.err", misalign_err, 1'b1);

    // PC wrap from FFFE to 0000.
    step(0, 1, 16'hFFFE, 0, "wrap_redir");
    step(0, 0, 16'h0, 0, "wrap1");
    chk("wrap.addr", imem_addr, 16'h0000);
    chk("wrap.pc2", if_id_pc_plus2, 16'h0000);
    step(0, 0, 16'h0, 0, "wrap2");

    // Flush alone and with stall.
    step(0, 0, 16'h0, 1, "flush");
    step(1, 0, 16'h0, 1, "flush_stall");

    // Asynchronous reset mid-cycle during a stall.
    step(1, 0, 16'h0, 0, "stall_pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1 chk_all("async_rst");
    chk("async_rst.err", misalign_err, 1'b0);
    @(negedge clk) begin rst = 1'b0; stall = 0; end
    step(0, 0, 16'h0, 0, "resume");
    chk("resume.instr", if_id_instr, 16'h1010);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, ($urandom % 10) == 0, 16'($urandom),
           ($urandom % 10) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
